// File: rtl/hangman_engine.sv
// Hangman game core: stores a secret word typed as key codes, then scores
// guesses (hit / repeat / miss) and reports a registered game state plus
// flat display and reveal vectors for the VGA and LED front ends.
module hangman_engine #(
    parameter int                 MAX_LEN    = 10,
    parameter int                 MAX_MISSES = 5,
    parameter int                 CODE_W     = 8,
    parameter logic [CODE_W-1:0]  ENTER_CODE = 8'h5A,
    parameter logic [CODE_W-1:0]  END_CODE   = 8'h5D,
    parameter logic [CODE_W-1:0]  MASK_CODE  = 8'h01,
    parameter int                 LEN_W      = 5,
    parameter int                 MISS_W     = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       key_valid,
    input  logic [CODE_W-1:0]          key_code,
    input  logic                       new_game,
    output logic [1:0]                 state,
    output logic [LEN_W-1:0]           word_len,
    output logic [MISS_W-1:0]          misses,
    output logic [MAX_LEN-1:0]         reveal,
    output logic [MAX_LEN*CODE_W-1:0]  disp_flat,
    output logic                       hit,
    output logic                       dup,
    output logic [7:0]                 led
);

    typedef enum logic [1:0] {
        ST_SETUP = 2'd0,
        ST_PLAY  = 2'd1,
        ST_WIN   = 2'd2,
        ST_LOSE  = 2'd3
    } state_t;

    state_t                       state_r, state_s;
    logic [LEN_W-1:0]             word_len_r, word_len_s;
    logic [MISS_W-1:0]            misses_r, misses_s;
    logic [MAX_LEN-1:0]           reveal_r, reveal_s;
    logic [MAX_LEN*CODE_W-1:0]    disp_r, disp_s;
    logic [MAX_LEN*CODE_W-1:0]    letters_r, letters_s;
    logic [MAX_MISSES*CODE_W-1:0] hist_r, hist_s;
    logic [CODE_W-1:0]            pend_r, pend_s;
    logic                         pend_v_r, pend_v_s;
    logic                         hit_r, hit_s;
    logic                         dup_r, dup_s;
    logic [7:0]                   led_r, led_s;

    logic [MAX_LEN-1:0]           slot_sel_s;
    logic [MAX_LEN-1:0]           match_s;
    logic [MAX_LEN-1:0]           fresh_s;
    logic [MAX_MISSES-1:0]        hist_sel_s;
    logic                         in_hist_s;
    logic                         key_s;

    // Slot decode and parallel comparison of the pending letter against word and miss history
    always_comb begin
        key_s      = key_valid && (key_code != {CODE_W{1'b0}});
        slot_sel_s = '0;
        match_s    = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            slot_sel_s[i] = (i == int'(word_len_r));
            match_s[i]    = (i < int'(word_len_r)) &&
                            (letters_r[i*CODE_W +: CODE_W] == pend_r);
        end
        fresh_s    = match_s & ~reveal_r;
        in_hist_s  = 1'b0;
        hist_sel_s = '0;
        for (int j = 0; j < MAX_MISSES; j++) begin
            hist_sel_s[j] = (j == int'(misses_r));
            in_hist_s     = in_hist_s |
                            ((j < int'(misses_r)) && (hist_r[j*CODE_W +: CODE_W] == pend_r));
        end
    end

    // Next-state and next-output computation; new_game wins over any key event
    always_comb begin
        state_s    = state_r;
        word_len_s = word_len_r;
        misses_s   = misses_r;
        reveal_s   = reveal_r;
        disp_s     = disp_r;
        letters_s  = letters_r;
        hist_s     = hist_r;
        pend_s     = pend_r;
        pend_v_s   = pend_v_r;
        hit_s      = 1'b0;
        dup_s      = 1'b0;
        if (new_game) begin
            state_s    = ST_SETUP;
            word_len_s = '0;
            misses_s   = '0;
            reveal_s   = '1;
            disp_s     = '0;
            letters_s  = '0;
            hist_s     = '0;
            pend_s     = '0;
            pend_v_s   = 1'b0;
        end else if (key_s) begin
            case (state_r)
                ST_SETUP: begin
                    if (key_code == ENTER_CODE) begin
                        if (word_len_r == LEN_W'(MAX_LEN)) begin
                            state_s  = ST_PLAY;
                            pend_s   = '0;
                            pend_v_s = 1'b0;
                        end else if (pend_v_r) begin
                            for (int i = 0; i < MAX_LEN; i++) begin
                                letters_s[i*CODE_W +: CODE_W] = slot_sel_s[i] ? pend_r
                                                              : letters_r[i*CODE_W +: CODE_W];
                                disp_s[i*CODE_W +: CODE_W]    = slot_sel_s[i] ? MASK_CODE
                                                              : disp_r[i*CODE_W +: CODE_W];
                            end
                            reveal_s   = reveal_r & ~slot_sel_s;
                            word_len_s = word_len_r + LEN_W'(1);
                            pend_v_s   = 1'b0;
                        end else begin
                            pend_v_s = 1'b0;
                        end
                    end else if (key_code == END_CODE) begin
                        if (word_len_r != {LEN_W{1'b0}}) begin
                            state_s  = ST_PLAY;
                            pend_s   = '0;
                            pend_v_s = 1'b0;
                        end else begin
                            state_s = ST_SETUP;
                        end
                    end else begin
                        // Out-of-range slot (word full) has no select bit, so nothing is shown
                        pend_s   = key_code;
                        pend_v_s = 1'b1;
                        for (int i = 0; i < MAX_LEN; i++) begin
                            disp_s[i*CODE_W +: CODE_W] = slot_sel_s[i] ? key_code
                                                       : disp_r[i*CODE_W +: CODE_W];
                        end
                    end
                end
                ST_PLAY: begin
                    if (key_code == ENTER_CODE) begin
                        if (pend_v_r) begin
                            pend_v_s = 1'b0;
                            if (fresh_s != {MAX_LEN{1'b0}}) begin
                                reveal_s = reveal_r | fresh_s;
                                for (int i = 0; i < MAX_LEN; i++) begin
                                    disp_s[i*CODE_W +: CODE_W] = fresh_s[i] ? pend_r
                                                               : disp_r[i*CODE_W +: CODE_W];
                                end
                                hit_s = 1'b1;
                            end else if ((match_s != {MAX_LEN{1'b0}}) || in_hist_s) begin
                                dup_s = 1'b1;
                            end else begin
                                misses_s = misses_r + MISS_W'(1);
                                for (int j = 0; j < MAX_MISSES; j++) begin
                                    hist_s[j*CODE_W +: CODE_W] = hist_sel_s[j] ? pend_r
                                                               : hist_r[j*CODE_W +: CODE_W];
                                end
                            end
                            // Decide on the post-update values of this same edge
                            if (&reveal_s) begin
                                state_s = ST_WIN;
                            end else if (misses_s == MISS_W'(MAX_MISSES)) begin
                                state_s = ST_LOSE;
                            end else begin
                                state_s = ST_PLAY;
                            end
                        end else begin
                            pend_v_s = 1'b0;
                        end
                    end else if (key_code == END_CODE) begin
                        state_s = ST_PLAY;
                    end else begin
                        pend_s   = key_code;
                        pend_v_s = 1'b1;
                    end
                end
                ST_WIN, ST_LOSE: begin
                    state_s = state_r;
                end
                default: begin
                    state_s = ST_SETUP;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // LED status follows the state that will be registered this edge
    always_comb begin
        case (state_s)
            ST_SETUP: led_s = 8'(pend_s);
            ST_PLAY:  led_s = 8'(misses_s);
            ST_WIN:   led_s = 8'hFF;
            ST_LOSE:  led_s = 8'hF0;
            default:  led_s = 8'h00;
        endcase
    end

    // State and output registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_SETUP;
            word_len_r <= '0;
            misses_r   <= '0;
            reveal_r   <= '1;
            disp_r     <= '0;
            letters_r  <= '0;
            hist_r     <= '0;
            pend_r     <= '0;
            pend_v_r   <= 1'b0;
            hit_r      <= 1'b0;
            dup_r      <= 1'b0;
            led_r      <= 8'h00;
        end else begin
            state_r    <= state_s;
            word_len_r <= word_len_s;
            misses_r   <= misses_s;
            reveal_r   <= reveal_s;
            disp_r     <= disp_s;
            letters_r  <= letters_s;
            hist_r     <= hist_s;
            pend_r     <= pend_s;
            pend_v_r   <= pend_v_s;
            hit_r      <= hit_s;
            dup_r      <= dup_s;
            led_r      <= led_s;
        end
    end

    assign state     = state_r;
    assign word_len  = word_len_r;
    assign misses    = misses_r;
    assign reveal    = reveal_r;
    assign disp_flat = disp_r;
    assign hit       = hit_r;
    assign dup       = dup_r;
    assign led       = led_r;

endmodule
